// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: actuator state encoding, phase/mode codes and
// the per-mode phase timing table (also used by the controller).
package wm_pkg;

    typedef enum logic [2:0] {
        P_IDLE,
        P_FILL,
        P_RUN,
        P_DRAIN,
        P_RAMPDN,
        P_DONE,
        P_FAULT
    } wm_state_e;

    // Encoding matches the bit position of the strobe in {spin, rinse, wash, soak}.
    typedef enum logic [1:0] {
        PH_SOAK,
        PH_WASH,
        PH_RINSE,
        PH_SPIN
    } wm_phase_e;

    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;  // illegal

    function automatic logic [2:0] phase_ticks(input logic [1:0] mode, input wm_phase_e phase);
        logic [2:0] t;
        case (mode)
            MODE0:   t = (phase == PH_SOAK) ? 3'd1 : 3'd2;
            MODE1:   t = (phase == PH_SOAK) ? 3'd2 : 3'd3;
            MODE2:   t = (phase == PH_SOAK) ? 3'd3 : 3'd5;
            default: t = 3'd1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// Time-tick prescaler: counts 0..CLK_PER_TICK-1, tick_o high on the wrap cycle,
// synchronous clear restarts the count so a state's first tick is a full period away.
module wm_tick_gen #(
    parameter int unsigned CLK_PER_TICK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(CLK_PER_TICK);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(CLK_PER_TICK - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wm_actuator_drv.sv
// Washing-machine actuator driver: turns the controller's phase strobes into valve, pump,
// motor and door-lock drive, reports phase_done and flags illegal command combinations.
module wm_actuator_drv
    import wm_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 4,
    parameter int unsigned FILL_TICKS   = 1,
    parameter int unsigned DRAIN_TICKS  = 1,
    parameter int unsigned AGIT_SPEED   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soak_op,
    input  logic       wash_op,
    input  logic       rinse_op,
    input  logic       spin_op,
    input  logic       water_inlet,
    input  logic [1:0] mode,
    input  logic       lid,
    output logic       valve_open,
    output logic       drain_pump,
    output logic       motor_en,
    output logic       motor_dir,
    output logic [2:0] motor_speed,
    output logic       door_lock,
    output logic       phase_done,
    output logic       fault
);

    wm_state_e  state_q, state_d;
    wm_phase_e  phase_q, phase_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] cnt_q, cnt_d;

    logic       valve_open_q, valve_open_d;
    logic       drain_pump_q, drain_pump_d;
    logic       motor_en_q, motor_en_d;
    logic       motor_dir_q, motor_dir_d;
    logic [2:0] motor_speed_q, motor_speed_d;
    logic       door_lock_q, door_lock_d;
    logic       phase_done_q, phase_done_d;
    logic       fault_q, fault_d;

    logic       tick;
    logic [3:0] strb;
    logic       multi, any, act, other;
    logic [7:0] run_tgt;

    assign strb    = {spin_op, rinse_op, wash_op, soak_op};
    assign any     = |strb;
    assign multi   = |(strb & (strb - 4'd1));
    assign act     = strb[phase_q];
    assign other   = |(strb & ~(4'b0001 << phase_q));
    assign run_tgt = 8'(phase_ticks(mode_q, phase_q));

    wm_tick_gen #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_d != state_q),
        .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        case (state_q)
            P_IDLE: begin
                if (multi || (any && mode == MODE3)) begin
                    state_d = P_FAULT;
                end else if (any && !lid) begin
                    mode_d = mode;
                    case (strb)
                        4'b0010: phase_d = PH_WASH;
                        4'b0100: phase_d = PH_RINSE;
                        4'b1000: phase_d = PH_SPIN;
                        default: phase_d = PH_SOAK;
                    endcase
                    state_d = (soak_op || rinse_op) ? P_FILL : P_RUN;
                end
            end
            P_FILL, P_RUN, P_DRAIN, P_RAMPDN: begin
                if (other) begin
                    state_d = P_FAULT;
                end else if (!act || lid) begin
                    state_d = P_IDLE;
                end else if (tick) begin
                    case (state_q)
                        P_FILL: begin
                            if (water_inlet && cnt_q == 8'(FILL_TICKS - 1)) state_d = P_RUN;
                        end
                        P_RUN: begin
                            if (cnt_q == run_tgt - 8'd1) begin
                                case (phase_q)
                                    PH_RINSE: state_d = P_DRAIN;
                                    PH_SPIN:  state_d = P_RAMPDN;
                                    default:  state_d = P_DONE;
                                endcase
                            end
                        end
                        P_DRAIN: begin
                            if (cnt_q == 8'(DRAIN_TICKS - 1)) state_d = P_DONE;
                        end
                        default: begin
                            if (motor_speed_q <= 3'd1) state_d = P_DONE;
                        end
                    endcase
                end
            end
            P_DONE: begin
                if (other) begin
                    state_d = P_FAULT;
                end else if (!act) begin
                    state_d = P_IDLE;
                end
            end
            P_FAULT: begin
                if (!any) state_d = P_IDLE;
            end
            default: state_d = P_IDLE;
        endcase
    end

    // Fill ticks only count while water is actually permitted.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && (state_q != P_FILL || water_inlet)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        valve_open_d  = 1'b0;
        drain_pump_d  = 1'b0;
        motor_en_d    = 1'b0;
        motor_dir_d   = 1'b0;
        motor_speed_d = 3'd0;
        case (state_d)
            P_FILL: valve_open_d = water_inlet;
            P_RUN: begin
                case (phase_d)
                    PH_WASH, PH_RINSE: begin
                        motor_en_d    = 1'b1;
                        motor_speed_d = 3'(AGIT_SPEED);
                        if (state_q == P_RUN) motor_dir_d = tick ? ~motor_dir_q : motor_dir_q;
                    end
                    PH_SPIN: begin
                        drain_pump_d = 1'b1;
                        motor_en_d   = 1'b1;
                        if (state_q != P_RUN) begin
                            motor_speed_d = 3'd1;
                        end else if (tick && motor_speed_q != 3'd7) begin
                            motor_speed_d = motor_speed_q + 3'd1;
                        end else begin
                            motor_speed_d = motor_speed_q;
                        end
                    end
                    default: ;
                endcase
            end
            P_DRAIN: drain_pump_d = 1'b1;
            P_RAMPDN: begin
                // Entry happens on a tick, so the first step down is taken on entry.
                drain_pump_d  = 1'b1;
                motor_en_d    = 1'b1;
                motor_speed_d = tick ? motor_speed_q - 3'd1 : motor_speed_q;
            end
            default: ;
        endcase
        door_lock_d  = (state_d != P_IDLE) && (state_d != P_FAULT);
        phase_done_d = (state_q == P_DONE) && (state_d != P_FAULT);
        fault_d      = fault_q || (state_d == P_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= P_IDLE;
            phase_q       <= PH_SOAK;
            mode_q        <= MODE0;
            cnt_q         <= '0;
            valve_open_q  <= 1'b0;
            drain_pump_q  <= 1'b0;
            motor_en_q    <= 1'b0;
            motor_dir_q   <= 1'b0;
            motor_speed_q <= 3'd0;
            door_lock_q   <= 1'b0;
            phase_done_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            valve_open_q  <= valve_open_d;
            drain_pump_q  <= drain_pump_d;
            motor_en_q    <= motor_en_d;
            motor_dir_q   <= motor_dir_d;
            motor_speed_q <= motor_speed_d;
            door_lock_q   <= door_lock_d;
            phase_done_q  <= phase_done_d;
            fault_q       <= fault_d;
        end
    end

    assign valve_open  = valve_open_q;
    assign drain_pump  = drain_pump_q;
    assign motor_en    = motor_en_q;
    assign motor_dir   = motor_dir_q;
    assign motor_speed = motor_speed_q;
    assign door_lock   = door_lock_q;
    assign phase_done  = phase_done_q;
    assign fault       = fault_q;

endmodule
